// File: rtl/logic_capture.sv
// Triggered logic-analyser capture: circular sample buffer with pre-trigger
// history, level/edge/force trigger and a ready/valid readout of DEPTH samples.
module logic_capture #(
  parameter int CHANNELS = 8,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] digital,
  input  logic                arm,
  input  logic                abort,
  input  logic [1:0]          trig_mode,
  input  logic [CHANNELS-1:0] trig_mask,
  input  logic [CHANNELS-1:0] trig_value,
  input  logic [ADDR_W-1:0]   pre_count,
  output logic                rd_valid,
  output logic [CHANNELS-1:0] rd_data,
  output logic                rd_last,
  input  logic                rd_ready,
  output logic [2:0]          status
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [1:0]          mode_q;
  logic [CHANNELS-1:0] mask_q, value_q, prev_q, mem_q;
  logic [ADDR_W-1:0]   pre_q, wr_ptr, cnt, rd_ptr, rd_idx, fetch_addr;
  logic                prev_valid;
  logic                arm_ok, capturing, hit, trigger, handshake;

  logic [CHANNELS-1:0] mem [DEPTH];

  assign arm_ok     = arm && !abort && (state == S_IDLE);
  assign capturing  = sample_en && !abort &&
                      ((state == S_FILL) || (state == S_ARMED) || (state == S_POST));
  assign handshake  = rd_valid && rd_ready;
  assign rd_last    = rd_valid && (rd_idx == '1);
  assign rd_data    = mem_q;
  assign status     = state;
  // Look one address ahead on a handshake so readout sustains one sample per cycle.
  assign fetch_addr = handshake ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    hit = 1'b0;
    unique case (mode_q)
      2'b00: hit = ((digital & mask_q) == (value_q & mask_q));
      2'b01: hit = prev_valid && ((~prev_q & digital & mask_q) != '0);
      2'b10: hit = prev_valid && ((prev_q & ~digital & mask_q) != '0);
      2'b11: hit = 1'b1;
    endcase
  end

  assign trigger = capturing && (state == S_ARMED) && hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (arm) state_nxt = (pre_count != '0) ? S_FILL : S_ARMED;
      S_FILL:    if (sample_en && (cnt == pre_q - 1'b1)) state_nxt = S_ARMED;
      S_ARMED:   if (trigger) state_nxt = (pre_q == '1) ? S_READOUT : S_POST;
      S_POST:    if (sample_en && (cnt == ADDR_W'(1))) state_nxt = S_READOUT;
      S_READOUT: if (handshake && rd_last) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (capturing) mem[wr_ptr] <= digital;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= '0;
      mask_q     <= '0;
      value_q    <= '0;
      pre_q      <= '0;
      wr_ptr     <= '0;
      prev_q     <= '0;
      prev_valid <= 1'b0;
      cnt        <= '0;
      rd_ptr     <= '0;
      rd_idx     <= '0;
      rd_valid   <= 1'b0;
      mem_q      <= '0;
    end else begin
      if (arm_ok) begin
        mode_q     <= trig_mode;
        mask_q     <= trig_mask;
        value_q    <= trig_value;
        pre_q      <= pre_count;
        wr_ptr     <= '0;
        cnt        <= '0;
        prev_valid <= 1'b0;
      end
      if (capturing) begin
        wr_ptr     <= wr_ptr + 1'b1;
        prev_q     <= digital;
        prev_valid <= 1'b1;
        if (state == S_FILL) cnt <= cnt + 1'b1;
        if (state == S_POST) cnt <= cnt - 1'b1;
      end
      // On trigger cnt becomes the number of post-trigger samples still to take.
      if (trigger) begin
        rd_ptr <= wr_ptr - pre_q;
        rd_idx <= '0;
        cnt    <= ~pre_q;
      end
      if ((state == S_READOUT) && !abort) begin
        mem_q <= mem[fetch_addr];
        if (!rd_valid) begin
          rd_valid <= 1'b1;
        end else if (handshake) begin
          rd_ptr <= rd_ptr + 1'b1;
          rd_idx <= rd_idx + 1'b1;
          if (rd_last) rd_valid <= 1'b0;
        end
      end
      if (abort) rd_valid <= 1'b0;
    end
  end

endmodule

// File: doc/logic_capture.md
LOGIC_CAPTURE -- requirements
Module: logic_capture

Interface
REQ-001 Parameter CHANNELS, default 8: number of digital input channels captured per sample.
REQ-002 Parameter DEPTH, default 1024: capture buffer depth in samples; power of two, minimum 4.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): buffer address width.
REQ-004 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port reset_n  input  1: asynchronous, active-low reset.
REQ-006 Port sample_en  input  1: sample strobe; one sample taken per cycle it is high.
REQ-007 Port digital  input  CHANNELS: digital inputs, already synchronised to clk.
REQ-008 Port arm  input  1: single-cycle request to start a capture.
REQ-009 Port abort  input  1: single-cycle request to cancel any activity.
REQ-010 Port trig_mode  input  2: trigger mode; 00 level, 01 rising, 10 falling, 11 force.
REQ-011 Port trig_mask  input  CHANNELS: channels taking part in the trigger.
REQ-012 Port trig_value  input  CHANNELS: level-mode match pattern.
REQ-013 Port pre_count  input  ADDR_W: pre-trigger sample count; range 0..DEPTH-1.
REQ-014 Port rd_valid  output  1: readout sample valid.
REQ-015 Port rd_data  output  CHANNELS: readout sample.
REQ-016 Port rd_last  output  1: high with the final (DEPTH-th) readout sample.
REQ-017 Port rd_ready  input  1: consumer accepts rd_data when rd_valid and rd_ready are both high.
REQ-018 Port status  output  3: current state; IDLE=0, FILL=1, ARMED=2, POST=3, READOUT=4.

Function
REQ-019 FSM transitions: IDLE -arm-> FILL (pre_count>0) or ARMED (pre_count=0); FILL -> ARMED after pre_count samples written; ARMED -trigger-> POST; POST -> READOUT after DEPTH-pre_count-1 further samples; READOUT -> IDLE on rd_last handshake.
REQ-020 trig_mode, trig_mask, trig_value and pre_count are latched on the accepted arm; later changes have no effect until the next arm.
REQ-021 arm outside IDLE is ignored.
REQ-022 abort in any state forces IDLE next cycle, deasserts rd_valid and discards the capture; abort has priority over arm in the same cycle.
REQ-023 In FILL, ARMED and POST, each sample_en cycle writes digital at the write pointer; the pointer increments modulo DEPTH and starts at 0 on arm.
REQ-024 Trigger is evaluated only in ARMED, only on sample_en cycles, against the current sample; the triggering sample is itself written to the buffer.
REQ-025 Level mode: trigger when (digital & mask) == (value & mask); a zero mask triggers on the first ARMED sample.
REQ-026 Rising mode: trigger when any masked bit is 0 in the previous sample and 1 in the current one; falling mode is the inverse; a zero mask never triggers.
REQ-027 The previous-sample register updates on every sample_en cycle from arm onwards; an edge is not detectable on the first sample after arm.
REQ-028 Force mode triggers on the first ARMED sample.
REQ-029 Trigger address T is the write address of the triggering sample; readout start is (T - pre_count) mod DEPTH.
REQ-030 In ARMED, the buffer wraps indefinitely; samples older than pre_count before T are never read out.
REQ-031 READOUT presents exactly DEPTH samples in write order from the start address, wrapping modulo DEPTH; the triggering sample is at index pre_count.
REQ-032 The buffer uses a synchronous single-cycle read; rd_valid first rises 1 or 2 cycles after READOUT entry.
REQ-033 While rd_valid is high and rd_ready is low, rd_data, rd_last and rd_valid hold stable.
REQ-034 A new sample is offered no later than the cycle after each handshake; back-to-back handshakes are sustained at one per cycle when rd_ready stays high.
REQ-035 sample_en is ignored in IDLE and READOUT.

Reset
REQ-036 While reset_n is low: status=IDLE, rd_valid=0, rd_last=0, rd_data=0, write pointer=0, previous-sample register=0; buffer contents undefined.
REQ-037 Reset asserted mid-capture or mid-readout discards all state; after release the block stays in IDLE until arm.

Verification
REQ-038 CHANNELS=8, DEPTH=16, pre_count=4, level mode, mask=0xFF, value=0x0A; ramp 0x00.. on sample_en -> trigger at 0x0A; readout is 0x06..0x15 with rd_last on 0x15.
REQ-039 Rising mode, mask=0x01, pre_count=0, bit0 high on the first sample after arm -> no trigger; the next 0->1 transition triggers and becomes readout index 0.
REQ-040 Force mode, pre_count=15, DEPTH=16 -> FILL for 15 samples, trigger on the 16th; 16 samples read out, triggering sample last.
REQ-041 Readout with rd_ready toggled randomly -> no sample lost or duplicated; rd_data stable while stalled; rd_ready held high -> one sample per cycle.
REQ-042 abort in ARMED, and reset_n pulsed low during READOUT -> status=IDLE, rd_valid=0; a following arm captures correctly.
REQ-043 arm issued during POST -> ignored; the capture completes unchanged.
